// File: rtl/ad9945_serial_rx.sv
// Responder side of the AD9945 3-wire serial port: oversamples SL/SCK/SDATA on sys_clk and
// decodes 15-bit LSB-first write frames into shadow copies of the four AFE registers.
module ad9945_serial_rx #(
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned DATA_BITS = 12,
  parameter logic [6:0]  OPER_RST  = 7'h00,
  parameter logic [6:0]  CTRL_RST  = 7'h00,
  parameter logic [7:0]  CLAMP_RST = 8'h00,
  parameter logic [9:0]  VGA_RST   = 10'h000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 SL,
  input  logic                 SCK,
  input  logic                 SDATA,
  output logic [6:0]           oper,
  output logic [6:0]           ctrl,
  output logic [7:0]           clamp,
  output logic [9:0]           vga_gain,
  output logic                 wr_stb,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err
);

  localparam int unsigned FrameLen = ADDR_BITS + DATA_BITS;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  typedef enum logic [1:0] {StIdle, StShift, StOvf} state_e;

  // [0]=s1, [1]=s2, [2]=s3
  logic [2:0] sl_q, sck_q;
  logic [1:0] sdata_q;
  logic [1:0] vld_q;
  logic       armed_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FrameLen-1:0]   shreg_q, shreg_d;
  logic                  commit, err;

  logic [6:0]            oper_q, ctrl_q;
  logic [7:0]            clamp_q;
  logic [9:0]            vga_q;
  logic                  wr_stb_q, frame_err_q;
  logic [ADDR_BITS-1:0]  wr_addr_q;
  logic [DATA_BITS-1:0]  wr_data_q;

  logic                  sck_rise, sl_rise, sl_fall, sdata_bit, addr_ok;
  logic [ADDR_BITS-1:0]  frame_addr;
  logic [DATA_BITS-1:0]  frame_data;

  // SL chain resets high, so an SL still low at release would look like a fall; armed_q
  // waits until a genuine high level has reached s2 before any fall is accepted.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sl_q    <= 3'b111;
      sck_q   <= 3'b000;
      sdata_q <= 2'b00;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sl_q    <= {sl_q[1:0], SL};
      sck_q   <= {sck_q[1:0], SCK};
      sdata_q <= {sdata_q[0], SDATA};
      vld_q   <= {vld_q[0], 1'b1};
      if (vld_q[1] && sl_q[1]) armed_q <= 1'b1;
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sl_rise   = sl_q[1] & ~sl_q[2];
  assign sl_fall   = armed_q & ~sl_q[1] & sl_q[2];
  assign sdata_bit = sdata_q[1];

  assign frame_addr = shreg_q[ADDR_BITS-1:0];
  assign frame_data = shreg_q[FrameLen-1:ADDR_BITS];
  assign addr_ok    = (32'(frame_addr) <= 32'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    commit  = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sl_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        // sl_rise wins over a coincident sck_rise
        if (sl_rise) begin
          state_d = StIdle;
          if (cnt_q == CntW'(FrameLen) && addr_ok) commit = 1'b1;
          else                                     err    = 1'b1;
        end else if (sck_rise) begin
          if (cnt_q == CntW'(FrameLen)) begin
            state_d = StOvf;
          end else begin
            shreg_d = {sdata_bit, shreg_q[FrameLen-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      StOvf: begin
        if (sl_rise) begin
          state_d = StIdle;
          err     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      oper_q      <= OPER_RST;
      ctrl_q      <= CTRL_RST;
      clamp_q     <= CLAMP_RST;
      vga_q       <= VGA_RST;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      wr_stb_q    <= commit;
      frame_err_q <= err;
      if (commit) begin
        wr_addr_q <= frame_addr;
        wr_data_q <= frame_data;
        case (32'(frame_addr))
          0:       oper_q  <= frame_data[6:0];
          1:       ctrl_q  <= frame_data[6:0];
          2:       clamp_q <= frame_data[7:0];
          3:       vga_q   <= frame_data[9:0];
          default: ;
        endcase
      end
    end
  end

  assign oper      = oper_q;
  assign ctrl      = ctrl_q;
  assign clamp     = clamp_q;
  assign vga_gain  = vga_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ad9945_serial_rx.sv
// Bench for ad9945_serial_rx: a frame-level model queues the expected commit/error events and a
// negedge monitor pops and checks them against wr_stb/frame_err pulses and the shadow registers.
module tb_ad9945_serial_rx;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        SL, SCK, SDATA;
  logic [6:0]  oper, ctrl;
  logic [7:0]  clamp;
  logic [9:0]  vga_gain;
  logic        wr_stb, frame_err;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;

  ad9945_serial_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .SL        (SL),
    .SCK       (SCK),
    .SDATA     (SDATA),
    .oper      (oper),
    .ctrl      (ctrl),
    .clamp     (clamp),
    .vga_gain  (vga_gain),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [11:0] d;
    logic [6:0]  oper;
    logic [6:0]  ctrl;
    logic [7:0]  clamp;
    logic [9:0]  vga;
    int          cyc;
  } ev_t;

  ev_t         q[$];
  ev_t         mon_ev;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [6:0]  m_oper, m_ctrl;
  logic [7:0]  m_clamp;
  logic [9:0]  m_vga;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // A frame commits only if it carried exactly 15 bits and addressed one of the four registers.
  function automatic void expect_frame(input int nbits, input logic [2:0] a, input logic [11:0] d);
    ev_t e;
    e.is_wr = (nbits == 15) && (a <= 3'd3);
    if (e.is_wr) begin
      case (a)
        3'd0: m_oper  = d[6:0];
        3'd1: m_ctrl  = d[6:0];
        3'd2: m_clamp = d[7:0];
        default: m_vga = d[9:0];
      endcase
    end
    e.a = a; e.d = d;
    e.oper = m_oper; e.ctrl = m_ctrl; e.clamp = m_clamp; e.vga = m_vga;
    // SL rises just after edge cyc: sampled at +1, outputs update at +3
    e.cyc = cyc + 3;
    q.push_back(e);
  endfunction

  always @(negedge sys_clk) begin
    if (wr_stb || frame_err) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got wr_stb=%0b frame_err=%0b, expected no pulse (cycle %0d)",
                 wr_stb, frame_err, cyc);
      end else begin
        mon_ev = q.pop_front();
        chk("pulse_wr_stb", 32'(wr_stb), 32'(mon_ev.is_wr));
        chk("pulse_frame_err", 32'(frame_err), 32'(!mon_ev.is_wr));
        chk("pulse_latency", 32'(cyc), 32'(mon_ev.cyc));
        if (mon_ev.is_wr) begin
          chk("wr_addr", 32'(wr_addr), 32'(mon_ev.a));
          chk("wr_data", 32'(wr_data), 32'(mon_ev.d));
        end
        chk("oper", 32'(oper), 32'(mon_ev.oper));
        chk("ctrl", 32'(ctrl), 32'(mon_ev.ctrl));
        chk("clamp", 32'(clamp), 32'(mon_ev.clamp));
        chk("vga_gain", 32'(vga_gain), 32'(mon_ev.vga));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_oper = 7'h00; m_ctrl = 7'h00; m_clamp = 8'h00; m_vga = 10'h000;
  endtask

  task automatic send_frame(input int nbits, input logic [2:0] a, input logic [11:0] d,
                            input bit coinc, input int hp);
    logic [14:0] w;
    w  = {d, a};
    SL = 1'b0;
    tick(hp);
    for (int i = 0; i < nbits; i++) begin
      SDATA = (i < 15) ? w[i] : 1'($urandom);
      tick(hp);
      SCK = 1'b1;
      tick(hp);
      SCK = 1'b0;
    end
    if (coinc) begin
      SDATA = 1'($urandom);
      tick(hp);
      SCK = 1'b1;
      SL  = 1'b1;
      expect_frame(nbits, a, d);
      tick(hp);
      SCK = 1'b0;
      tick(hp);
    end else begin
      tick(hp);
      SL = 1'b1;
      expect_frame(nbits, a, d);
      tick(hp + 2);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) tick(1);
    chk("events_outstanding", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_shadows(input string tag);
    chk({tag, "_oper"}, 32'(oper), 32'(m_oper));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(m_ctrl));
    chk({tag, "_clamp"}, 32'(clamp), 32'(m_clamp));
    chk({tag, "_vga_gain"}, 32'(vga_gain), 32'(m_vga));
  endtask

  initial begin
    logic [14:0] w;
    int          r, nbits;
    SL = 1'b1; SCK = 1'b0; SDATA = 1'b0;
    sys_rst_n = 1'b0;
    model_reset();
    tick(4);
    sys_rst_n = 1'b1;
    tick(20);
    chk_shadows("reset");
    chk("reset_wr_stb", 32'(wr_stb), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);

    send_frame(15, 3'd3, 12'h2A5, 1'b0, 4);
    drain();
    chk("single_vga_gain", 32'(vga_gain), 32'h2A5);

    send_frame(15, 3'd0, 12'hF7F, 1'b0, 4);
    send_frame(15, 3'd1, 12'h045, 1'b0, 4);
    send_frame(15, 3'd2, 12'h1C0, 1'b0, 4);
    send_frame(15, 3'd3, 12'h3FF, 1'b0, 4);
    drain();
    chk_shadows("b2b");

    send_frame(14, 3'd1, 12'hABC, 1'b0, 4);
    send_frame(16, 3'd0, 12'h011, 1'b0, 4);
    send_frame(15, 3'd5, 12'h123, 1'b0, 4);
    drain();
    chk_shadows("errs");

    // Reset in the middle of an A=2 frame: nothing may be reported afterwards.
    w  = {12'h0AA, 3'd2};
    SL = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      SDATA = w[i];
      tick(4);
      SCK = 1'b1;
      tick(4);
      SCK = 1'b0;
    end
    sys_rst_n = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    model_reset();
    tick(8);
    SL = 1'b1;
    tick(12);
    chk("midrst_clamp", 32'(clamp), 32'h00);
    chk_shadows("midrst");
    send_frame(15, 3'd2, 12'h055, 1'b0, 4);
    drain();
    chk("after_rst_clamp", 32'(clamp), 32'h55);

    send_frame(15, 3'd1, 12'h06B, 1'b1, 4);
    drain();
    chk("coinc_ctrl", 32'(ctrl), 32'h6B);

    for (int n = 0; n < 24; n++) begin
      r     = int'($urandom_range(0, 5));
      nbits = (r == 0) ? 14 : (r == 1) ? 16 : 15;
      send_frame(nbits, 3'($urandom_range(0, 7)), 12'($urandom),
                 (nbits == 15) && ($urandom_range(0, 4) == 0), int'($urandom_range(3, 5)));
    end
    drain();
    chk_shadows("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
